// File: rtl/data_memory_ws_pkg.sv
// Shared defaults and FSM encoding for the wait-stated MEM-stage data memory.
package data_memory_ws_pkg;

  localparam int MEM_BASE_ADDR   = 1024;
  localparam int MEM_DEPTH_BYTES = 2048;
  localparam int MEM_WAIT_CYCLES = 3;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_BUSY = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_e;

endpackage

// File: rtl/data_memory_ws_mem_byte_array.sv
// Byte storage with async clear, single-cycle byte/word write and a
// combinational big-endian read port (MSB at the lowest byte address).
module data_memory_ws_mem_byte_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BYTES = 2048,
  parameter int IW          = $clog2(DEPTH_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic                  i_byte,
  input  logic [IW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic [7:0]            o_byte
);

  localparam int NB = DATA_WIDTH / 8;

  logic [7:0]    r_mem [DEPTH_BYTES];
  logic [IW-1:0] w_idx [NB];
  logic [NB-1:0] w_ok;

  // Per-byte lane addresses; lanes past the end of storage read as zero
  // and are never written.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign w_idx[b] = i_addr + IW'(b);
    assign w_ok[b]  = (int'(i_addr) + b) < DEPTH_BYTES;
    assign o_word[DATA_WIDTH-1-8*b -: 8] = w_ok[b] ? r_mem[w_idx[b]] : 8'h00;
  end

  assign o_byte = w_ok[0] ? r_mem[i_addr] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      if (i_byte) begin
        if (w_ok[0]) r_mem[i_addr] <= i_wdata[7:0];
      end else begin
        for (int b = 0; b < NB; b++)
          if (w_ok[b]) r_mem[w_idx[b]] <= i_wdata[DATA_WIDTH-1-8*b -: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory_ws.sv
// MEM-stage data memory with WAIT_CYCLES busy cycles and a ready handshake;
// holds the access FSM, wait counter, window mapping and status flags.
module data_memory_ws
  import data_memory_ws_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = MEM_DEPTH_BYTES,
  parameter int BASE_ADDR   = MEM_BASE_ADDR,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic                  i_byte_mode,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_ready,
  output logic                  o_misaligned,
  output logic                  o_out_of_range
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AL = $clog2(NB);
  localparam int IW = $clog2(DEPTH_BYTES);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]         CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH    = (ADDR_WIDTH+1)'(DEPTH_BYTES);
  localparam bit                    NO_WAIT  = (WAIT_CYCLES == 0);

  mem_state_e r_state;
  logic [CW-1:0] r_cnt;

  // Latched request, captured when leaving IDLE.
  logic [IW-1:0]         r_idx;
  logic                  r_byte, r_wr, r_rd, r_req_oor, r_req_mis;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_mis, r_oor;

  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_phys;
  logic [ADDR_WIDTH:0]   w_size, w_end;
  logic                  w_oor, w_mis;
  logic [IW-1:0]         w_idx;

  assign w_req  = i_mem_read | i_mem_write;
  assign w_phys = i_addr - BASE;
  assign w_size = i_byte_mode ? (ADDR_WIDTH+1)'(1) : (ADDR_WIDTH+1)'(NB);
  assign w_end  = {1'b0, w_phys} + w_size;
  assign w_oor  = (i_addr < BASE) || (w_end > DEPTH);
  assign w_mis  = !i_byte_mode && (i_addr[AL-1:0] != '0);
  assign w_idx  = i_byte_mode ? w_phys[IW-1:0] : {w_phys[IW-1:AL], {AL{1'b0}}};

  // With no wait states the access commits on the IDLE edge from the live
  // inputs; otherwise it commits from the latched copy at the end of BUSY.
  logic                  c_byte, c_wr, c_rd, c_oor, c_mis, w_commit;
  logic [IW-1:0]         c_idx;
  logic [DATA_WIDTH-1:0] c_wdata, w_rword, w_rval;
  logic [7:0]            w_rbyte;

  assign c_idx   = NO_WAIT ? w_idx          : r_idx;
  assign c_byte  = NO_WAIT ? i_byte_mode    : r_byte;
  assign c_wr    = NO_WAIT ? i_mem_write    : r_wr;
  assign c_rd    = NO_WAIT ? i_mem_read     : r_rd;
  assign c_oor   = NO_WAIT ? w_oor          : r_req_oor;
  assign c_mis   = NO_WAIT ? w_mis          : r_req_mis;
  assign c_wdata = NO_WAIT ? i_write_data   : r_wdata;

  assign w_commit = NO_WAIT ? (r_state == MEM_IDLE && w_req)
                            : (r_state == MEM_BUSY && r_cnt == '0);

  data_memory_ws_mem_byte_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_BYTES(DEPTH_BYTES),
    .IW         (IW)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_commit & c_wr & !c_oor),
    .i_byte (c_byte),
    .i_addr (c_idx),
    .i_wdata(c_wdata),
    .o_word (w_rword),
    .o_byte (w_rbyte)
  );

  assign w_rval = c_oor  ? '0 :
                  c_byte ? {{(DATA_WIDTH-8){1'b0}}, w_rbyte} : w_rword;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= MEM_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_byte      <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_req_oor   <= 1'b0;
      r_req_mis   <= 1'b0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_mis       <= 1'b0;
      r_oor       <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: if (w_req) begin
          r_idx     <= w_idx;
          r_byte    <= i_byte_mode;
          r_wr      <= i_mem_write;
          r_rd      <= i_mem_read;
          r_req_oor <= w_oor;
          r_req_mis <= w_mis;
          r_wdata   <= i_write_data;
          r_cnt     <= CNT_INIT;
          r_state   <= NO_WAIT ? MEM_DONE : MEM_BUSY;
        end
        MEM_BUSY: begin
          if (r_cnt == '0) r_state <= MEM_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= MEM_IDLE;
      endcase
      // Read happens in the same edge as any write, so read+write returns old data.
      if (w_commit) begin
        if (c_rd) r_read_data <= w_rval;
        r_mis <= c_mis;
        r_oor <= c_oor;
      end
    end
  end

  always_comb begin
    o_ready = 1'b0;
    case (r_state)
      MEM_IDLE: o_ready = !w_req;
      MEM_DONE: o_ready = 1'b1;
      default:  o_ready = 1'b0;
    endcase
  end

  assign o_read_data    = r_read_data;
  assign o_misaligned   = r_mis;
  assign o_out_of_range = r_oor;

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench: a WAIT_CYCLES=3 instance and a WAIT_CYCLES=0 instance.
module tb_data_memory_ws;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_rd, a_wr, a_bm, a_rdy, a_mis, a_oor;
  logic [31:0] a_ad, a_wd, a_rdat;
  logic        z_rd, z_wr, z_bm, z_rdy, z_mis, z_oor;
  logic [31:0] z_ad, z_wd, z_rdat;

  data_memory_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_BYTES(2048),
                   .BASE_ADDR(1024), .WAIT_CYCLES(3)) u_d3 (
    .clk(clk), .rst(rst), .i_mem_read(a_rd), .i_mem_write(a_wr),
    .i_byte_mode(a_bm), .i_addr(a_ad), .i_write_data(a_wd),
    .o_read_data(a_rdat), .o_ready(a_rdy), .o_misaligned(a_mis),
    .o_out_of_range(a_oor));

  data_memory_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_BYTES(2048),
                   .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_d0 (
    .clk(clk), .rst(rst), .i_mem_read(z_rd), .i_mem_write(z_wr),
    .i_byte_mode(z_bm), .i_addr(z_ad), .i_write_data(z_wd),
    .o_read_data(z_rdat), .o_ready(z_rdy), .o_misaligned(z_mis),
    .o_out_of_range(z_oor));

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] g_rd;
  logic        g_mis, g_oor;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input bit rd, input bit wr, input bit bm,
                       input logic [31:0] ad, input logic [31:0] wd);
    if (w == 0) begin
      z_rd = rd; z_wr = wr; z_bm = bm; z_ad = ad; z_wd = wd;
    end else begin
      a_rd = rd; a_wr = wr; a_bm = bm; a_ad = ad; a_wd = wd;
    end
  endtask

  // One access: count ready-low cycles (bounded), sample results in DONE,
  // then drop the request before the DONE->IDLE edge.
  task automatic acc(input int w, input bit rd, input bit wr, input bit bm,
                     input logic [31:0] ad, input logic [31:0] wd, input string tag);
    int  lows;
    bit  done;
    @(negedge clk);
    drive(w, rd, wr, bm, ad, wd);
    #1;
    lows = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if ((w == 0) ? z_rdy : a_rdy) done = 1;
      else begin
        lows++;
        @(negedge clk);
        #1;
      end
    end
    chk({tag, " ready-low cycles"}, 32'(lows), (w == 0) ? 32'd1 : 32'd4);
    g_rd  = (w == 0) ? z_rdat : a_rdat;
    g_mis = (w == 0) ? z_mis  : a_mis;
    g_oor = (w == 0) ? z_oor  : a_oor;
    drive(w, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [9:0] pat;
    drive(3, 0, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ready",    32'(a_rdy), 32'd1);
    chk("reset rdata",    a_rdat,     32'h0);
    chk("reset mis",      32'(a_mis), 32'd0);
    chk("reset oor",      32'(a_oor), 32'd0);
    chk("reset ready w0", 32'(z_rdy), 32'd1);

    // Word store/load
    acc(3, 0, 1, 0, 32'd1024, 32'd8192, "s1 str");
    acc(3, 1, 0, 0, 32'd1024, 32'h0, "s1 ldr");
    chk("s1 rdata", g_rd, 32'h0000_2000);
    chk("s1 mis", 32'(g_mis), 32'd0);
    chk("s1 oor", 32'(g_oor), 32'd0);

    // Byte store into a word, big-endian placement
    acc(3, 0, 1, 0, 32'd1028, 32'hC000_0000, "s2 str");
    acc(3, 0, 1, 1, 32'd1029, 32'h1234_56AB, "s2 strb");
    acc(3, 1, 0, 0, 32'd1028, 32'h0, "s2 ldr");
    chk("s2 word", g_rd, 32'hC0AB_0000);
    acc(3, 1, 0, 1, 32'd1029, 32'h0, "s2 ldrb");
    chk("s2 byte", g_rd, 32'h0000_00AB);

    // Misaligned word load aligns down
    acc(3, 1, 0, 0, 32'd1030, 32'h0, "s3 ldr");
    chk("s3 word", g_rd, 32'hC0AB_0000);
    chk("s3 mis", 32'(g_mis), 32'd1);
    repeat (3) @(negedge clk);
    chk("s3 mis held", 32'(a_mis), 32'd1);
    acc(3, 1, 0, 1, 32'd1030, 32'h0, "s3 ldrb");
    chk("s3 byte", g_rd, 32'h0);
    chk("s3 byte mis", 32'(g_mis), 32'd0);

    // Window boundaries
    acc(3, 1, 0, 0, 32'h100, 32'h0, "s4 low ldr");
    chk("s4 low rdata", g_rd, 32'h0);
    chk("s4 low oor", 32'(g_oor), 32'd1);
    chk("s4 low mis", 32'(g_mis), 32'd0);
    acc(3, 0, 1, 0, 32'd3072, 32'hFFFF_FFFF, "s4 high str");
    chk("s4 high str oor", 32'(g_oor), 32'd1);
    acc(3, 1, 0, 0, 32'd3068, 32'h0, "s4 last ldr");
    chk("s4 last rdata", g_rd, 32'h0);
    chk("s4 last oor", 32'(g_oor), 32'd0);
    acc(3, 1, 0, 1, 32'd3071, 32'h0, "s4 last ldrb");
    chk("s4 last byte oor", 32'(g_oor), 32'd0);
    acc(3, 1, 0, 1, 32'd3072, 32'h0, "s4 past ldrb");
    chk("s4 past byte oor", 32'(g_oor), 32'd1);
    acc(3, 1, 0, 0, 32'h101, 32'h0, "s4 mis+oor");
    chk("s4 mo mis", 32'(g_mis), 32'd1);
    chk("s4 mo oor", 32'(g_oor), 32'd1);

    // Read+write together: write wins, read returns prior contents
    acc(3, 0, 1, 0, 32'd1044, 32'h1122_3344, "rbw str");
    acc(3, 1, 1, 0, 32'd1044, 32'h5566_7788, "rbw both");
    chk("rbw old data", g_rd, 32'h1122_3344);
    acc(3, 1, 0, 0, 32'd1044, 32'h0, "rbw ldr");
    chk("rbw new data", g_rd, 32'h5566_7788);

    // Request held across two accesses: second starts in the IDLE after DONE
    @(negedge clk);
    drive(3, 1, 0, 0, 32'd1024, 32'h0);
    #1;
    pat = '0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) begin
        @(negedge clk);
        #1;
      end
      pat[c] = a_rdy;
    end
    drive(3, 0, 0, 0, 32'h0, 32'h0);
    chk("b2b ready pattern", 32'(pat), 32'h210);

    // Reset during BUSY aborts the store and clears storage
    @(negedge clk);
    drive(3, 0, 1, 0, 32'd1040, 32'h55);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(3, 0, 0, 0, 32'h0, 32'h0);
    #1;
    chk("s5 ready after rst", 32'(a_rdy), 32'd1);
    chk("s5 rdata after rst", a_rdat, 32'h0);
    acc(3, 1, 0, 0, 32'd1040, 32'h0, "s5 ldr 1040");
    chk("s5 aborted store", g_rd, 32'h0);
    acc(3, 1, 0, 0, 32'd1024, 32'h0, "s5 ldr 1024");
    chk("s5 cleared storage", g_rd, 32'h0);

    // Zero wait-state build
    acc(0, 0, 1, 0, 32'd1036, 32'd41, "s6 str");
    acc(0, 1, 0, 0, 32'd1036, 32'h0, "s6 ldr");
    chk("s6 rdata", g_rd, 32'd41);
    acc(0, 1, 0, 1, 32'd1039, 32'h0, "s6 ldrb");
    chk("s6 byte", g_rd, 32'd41);
    acc(0, 1, 0, 0, 32'd3072, 32'h0, "s6 oor ldr");
    chk("s6 oor", 32'(g_oor), 32'd1);
    chk("s6 oor rdata", g_rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
Parameterised, byte-addressed, big-endian data memory for the ARM pipeline's MEM stage. It replaces the zero-latency word memory with a model that has configurable wait states and a ready handshake, so the hazard/stall logic can be exercised.
It supports word and byte access (LDR/STR, LDRB/STRB) and a base-address window, and it flags misaligned and out-of-window accesses.

Parameters:
DATA_WIDTH, 32, data word width; must be a multiple of 8.
ADDR_WIDTH, 32, CPU address width.
DEPTH_BYTES, 2048, storage size in bytes.
BASE_ADDR, 1024, CPU address that maps to storage byte 0.
WAIT_CYCLES, 3, number of BUSY cycles per access; 0 is legal.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  asynchronous, active-high reset.
mem_read  in  1  read request; held stable by the pipeline until ready=1.
mem_write  in  1  write request; held stable by the pipeline until ready=1.
byte_mode  in  1  1 = byte access; 0 = word access.
addr  in  ADDR_WIDTH  CPU byte address.
write_data  in  DATA_WIDTH  store data; byte access uses [7:0].
read_data  out  DATA_WIDTH  load result; registered.
ready  out  1  0 = stall the pipeline; 1 = access complete or no access pending.
misaligned  out  1  word access with addr[1:0]!=0; valid while ready=1 in DONE.
out_of_range  out  1  access outside the window; valid while ready=1 in DONE.

Behaviour:
- Reset (async, on rst edge, any state):
  - state=IDLE, counter=0.
  - read_data=0, misaligned=0, out_of_range=0.
  - All storage bytes cleared to 0. There is no program preload; programs live in instruction memory.
- Address mapping:
  - phys = addr - BASE_ADDR.
  - In window iff addr >= BASE_ADDR and phys + (byte_mode ? 1 : 4) <= DEPTH_BYTES.
- Word access:
  - Uses the aligned address phys with [1:0] forced to 00, for both read and write.
  - Word = {mem[p], mem[p+1], mem[p+2], mem[p+3]}, big-endian, MSB at the lowest address.
- Byte access:
  - Read returns {24'b0, mem[phys]}, zero-extended.
  - Write stores write_data[7:0] to mem[phys] only.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - ready = !(mem_read | mem_write), combinational.
    - On posedge with a request: latch addr, write_data, byte_mode and op; counter = WAIT_CYCLES-1.
    - Next state is BUSY, or DONE if WAIT_CYCLES=0.
  - BUSY:
    - ready=0.
    - Counter decrements each cycle.
    - At counter==0, the posedge commits the access and moves to DONE. Commit means: write the storage, or load read_data; set the flags.
  - DONE:
    - ready=1 for exactly one cycle.
    - The next posedge goes to IDLE unconditionally. A request in the following cycle is a new instruction.
- Latency: the request is visible for WAIT_CYCLES+2 cycles, with ready low for the first WAIT_CYCLES+1 of them.
- Outputs: read_data and the flags hold their values until the next commit.
- Write plus read together: treated as a write; read_data gets the pre-write contents (read-before-write).
- Out of range:
  - Write is suppressed.
  - read_data=0.
  - out_of_range=1; misaligned is still evaluated.
- Reset mid-access: the access is aborted, and an uncommitted write leaves storage at the reset value.
- Request inputs are ignored while in BUSY and DONE; only the latched copies are used.

Decomposition:
- defines.v:
  - MEM_BASE_ADDR, MEM_DEPTH_BYTES, MEM_WAIT_CYCLES defaults.
  - 2-bit state encodings MEM_IDLE=00, MEM_BUSY=01, MEM_DONE=10.
- Sub-module mem_byte_array holds the storage:
  - Contents: byte array, async clear, one-cycle write with byte/word select.
  - Interface: combinational big-endian word/byte read port.
- The top level holds the FSM, counter, address mapping and flags.

Test Plan:
1. WAIT_CYCLES=3. STR word 8192 to 1024, then LDR from 1024.
   - Each access: ready low 4 cycles, high 1 cycle.
   - read_data=0x00002000 and flags 0.
2. Word 0xC0000000 at 1028, then STRB 0xAB to 1029, then LDR 1028.
   - Result 0xC0AB0000.
   - LDRB 1029 returns 0x000000AB.
3. LDR at 1030 after scenario 2.
   - Returns 0xC0AB0000 (aligned to 1028) with misaligned=1.
   - LDRB 1030 gives misaligned=0.
4. Out-of-window accesses:
   - LDR at 0x100: read_data=0, out_of_range=1.
   - STR 0xFFFFFFFF to 1024+2048: ignored.
   - LDR 3068 still 0; out_of_range=0 for 3068.
5. STR 0x55 to 1040, with rst pulsed during BUSY cycle 2.
   - State returns to IDLE, ready=1 with no request, and LDR 1040 returns 0.
   - Back-to-back LDRs: the second starts in the IDLE cycle after DONE.
6. WAIT_CYCLES=0 build: every access shows ready low exactly 1 cycle; STR then LDR of 41 at 1036 returns 41.
